// File: rtl/cdb_arb_pkg.sv
// cdb_arb_pkg: shared definitions for the common-data-bus arbiter and its consumers.
// Holds the default bus widths, the requester slot assignment used by the core,
// and the broadcast packet layout seen by the ROB, reservation stations and RF.
package cdb_arb_pkg;

    localparam int CDB_TAG_W  = 6;
    localparam int CDB_DATA_W = 32;

    // Requester slots; a lower index means a higher fixed priority
    localparam int CDB_REQ_MDU = 0;
    localparam int CDB_REQ_LSU = 1;
    localparam int CDB_REQ_ALU = 2;

    typedef struct packed {
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] wdata;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_arb_age_ctr.sv
// cdb_arb_age_ctr: per-requester wait counter used by the aging guard of cdb_arb.
// Counts consecutive losing cycles, saturates at AGE_MAX, and flags the requester
// as aged once saturated so the arbiter can promote it over base priority.
module cdb_arb_age_ctr #(
    parameter int AGE_MAX = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic aged
);

    localparam int AGE_W = $clog2(AGE_MAX + 1);

    logic [AGE_W-1:0] age;

    assign aged = (age == AGE_W'(AGE_MAX));

    // Saturating wait counter; clear wins over increment
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            age <= '0;
        end else if (inc && !aged) begin
            age <= age + 1'b1;
        end
    end

endmodule

// File: rtl/cdb_arb.sv
// cdb_arb: common-data-bus writeback arbiter.
// Grants at most one of N_REQ requesters per cycle (combinational rdy, lowest
// index wins) and registers the winning tag/wdata onto the CDB one cycle later.
// Build option CDB_ARB_AGING_EN adds per-requester wait counters that promote a
// requester after AGE_MAX losing cycles; without it the arbiter is pure fixed
// priority and AGE_MAX is only range-checked.
module cdb_arb
    import cdb_arb_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int TAG_W   = CDB_TAG_W,
    parameter int DATA_W  = CDB_DATA_W,
    parameter int AGE_MAX = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*TAG_W-1:0]    tag,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    output logic [N_REQ-1:0]          rdy,
    output logic                      cdb_wr,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_wdata
);

    if (AGE_MAX < 1) begin : g_bad_age_max
        $error("cdb_arb: AGE_MAX must be at least 1");
    end

    logic [N_REQ-1:0]  aged;
    logic [N_REQ-1:0]  aged_req;
    logic [N_REQ-1:0]  base_oh;
    logic [N_REQ-1:0]  aged_oh;
    logic [TAG_W-1:0]  sel_tag;
    logic [DATA_W-1:0] sel_data;

    logic              vld_p1;
    logic [TAG_W-1:0]  tag_p1;
    logic [DATA_W-1:0] data_p1;

`ifdef CDB_ARB_AGING_EN
    for (genvar i = 0; i < N_REQ; i++) begin : g_age
        cdb_arb_age_ctr #(
            .AGE_MAX (AGE_MAX)
        ) u_ctr (
            .clk  (clk),
            .rst  (rst),
            .clr  (flush | ~req[i] | rdy[i]),
            .inc  (req[i] & ~rdy[i]),
            .aged (aged[i])
        );
    end
`else
    assign aged = '0;
`endif

    assign aged_req = req & aged;

    // Lowest-index pick among all requesters and among aged requesters
    always_comb begin
        base_oh = '0;
        aged_oh = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                base_oh    = '0;
                base_oh[i] = 1'b1;
            end
            if (aged_req[i]) begin
                aged_oh    = '0;
                aged_oh[i] = 1'b1;
            end
        end
    end

    // Grant: suppressed in reset/flush, aged requesters override base priority
    always_comb begin
        rdy = '0;
        if (!rst && !flush) begin
            rdy = (|aged_req) ? aged_oh : base_oh;
        end
    end

    // Winner payload mux; rdy is one-hot or zero so an OR-reduce suffices
    always_comb begin
        sel_tag  = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (rdy[i]) begin
                sel_tag  = sel_tag  | tag[i*TAG_W +: TAG_W];
                sel_data = sel_data | wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Stage p0 -> p1: broadcast register, killed by reset and flush
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_p1  <= 1'b0;
            tag_p1  <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1  <= |rdy;
            tag_p1  <= sel_tag;
            data_p1 <= sel_data;
        end
    end

    assign cdb_wr    = vld_p1;
    assign cdb_tag   = tag_p1;
    assign cdb_wdata = data_p1;

endmodule

// File: tb/tb_cdb_arb.sv
// tb_cdb_arb: self-checking bench for cdb_arb with a behavioural reference model.
// Directed scenarios pin the model with literal expectations; a randomized phase
// then runs against the model, which is checked every cycle on the falling edge.
// Honours CDB_ARB_AGING_EN the same way the design does.
module tb_cdb_arb;
    import cdb_arb_pkg::*;

    localparam int N  = 3;
    localparam int TW = 6;
    localparam int DW = 32;
    localparam int AM = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [N-1:0]    req;
    logic [N*TW-1:0] tag;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    rdy;
    logic            cdb_wr;
    logic [TW-1:0]   cdb_tag;
    logic [DW-1:0]   cdb_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    cdb_arb #(
        .N_REQ   (N),
        .TAG_W   (TW),
        .DATA_W  (DW),
        .AGE_MAX (AM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req       (req),
        .tag       (tag),
        .wdata     (wdata),
        .rdy       (rdy),
        .cdb_wr    (cdb_wr),
        .cdb_tag   (cdb_tag),
        .cdb_wdata (cdb_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Pending broadcast (what the CDB shows this cycle) and per-unit losing streaks.
    logic          m_wr   = 1'b0;
    logic [TW-1:0] m_tag  = '0;
    logic [DW-1:0] m_data = '0;
    int            m_age [N] = '{default: 0};

    always @(negedge clk) begin : model
        int           win;
        logic [N-1:0] e;
        win = -1;
        if (!rst && !flush) begin
`ifdef CDB_ARB_AGING_EN
            for (int i = 0; i < N; i++)
                if (win < 0 && req[i] && m_age[i] >= AM) win = i;
`endif
            for (int i = 0; i < N; i++)
                if (win < 0 && req[i]) win = i;
        end
        e = (win < 0) ? '0 : (N'(1) << win);
        check("model rdy", rdy, e);
        check("model cdb_wr", cdb_wr, m_wr);
        check("model cdb_tag", cdb_tag, m_tag);
        check("model cdb_wdata", cdb_wdata, m_data);
        if (rst) begin
            m_wr = 1'b0; m_tag = '0; m_data = '0;
            for (int i = 0; i < N; i++) m_age[i] = 0;
        end else begin
            m_wr   = (win >= 0);
            m_tag  = (win >= 0) ? tag[win*TW +: TW]   : '0;
            m_data = (win >= 0) ? wdata[win*DW +: DW] : '0;
            for (int i = 0; i < N; i++)
                if (flush || !req[i] || win == i) m_age[i] = 0;
                else m_age[i] = (m_age[i] < AM) ? m_age[i] + 1 : AM;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_unit(input int i, input logic [TW-1:0] t);
        tag[i*TW +: TW]   = t;
        wdata[i*DW +: DW] = 32'hA000_0000 | 32'(t);
    endtask

    initial begin
        logic [N-1:0] g;
        rst = 1'b1; flush = 1'b0; req = 3'b111; tag = '0; wdata = '0;
        set_unit(0, 6'd3); set_unit(1, 6'd4); set_unit(2, 6'd7);

        // Reset held with all requests up
        repeat (3) begin
            @(negedge clk);
            check("reset rdy", rdy, 0);
            check("reset cdb_wr", cdb_wr, 0);
            check("reset cdb_tag", cdb_tag, 0);
            check("reset cdb_wdata", cdb_wdata, 0);
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        check("first grant", rdy, 3'b001);
        tick();

        // Fixed priority
        req = 3'b110; set_unit(1, 6'd5); set_unit(2, 6'd9);
        @(negedge clk);
        check("prio rdy 110", rdy, 3'b010);
        check("prio prev tag", cdb_tag, 3);
        tick();
        req = 3'b100;
        @(negedge clk);
        check("prio rdy 100", rdy, 3'b100);
        check("prio cdb_wr", cdb_wr, 1);
        check("prio cdb_tag 5", cdb_tag, 5);
        check("prio cdb_wdata 5", cdb_wdata, 32'hA000_0005);
        tick();
        req = 3'b000;
        @(negedge clk);
        check("prio cdb_tag 9", cdb_tag, 9);
        tick();

        // Back-to-back broadcasts from unit 2
        req = 3'b100;
        for (int k = 1; k <= 4; k++) begin
            set_unit(2, TW'(k));
            @(negedge clk);
            check("b2b rdy", rdy, 3'b100);
            if (k > 1) begin
                check("b2b cdb_wr", cdb_wr, 1);
                check("b2b cdb_tag", cdb_tag, k - 1);
            end
            tick();
        end
        req = 3'b000;
        @(negedge clk);
        check("b2b last wr", cdb_wr, 1);
        check("b2b last tag", cdb_tag, 4);
        tick();
        @(negedge clk);
        check("b2b idle wr", cdb_wr, 0);
        tick();

        // Starvation / aging with units 0 and 2 held
        req = 3'b101; set_unit(0, 6'd20); set_unit(2, 6'd21);
`ifdef CDB_ARB_AGING_EN
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            check("aging rdy", rdy, (c == 8) ? 3'b100 : 3'b001);
            tick();
        end
`else
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            check("starve rdy2", rdy[2], 0);
            tick();
        end
`endif
        req = 3'b000;
        tick();

        // Flush kills the next broadcast, not the one already registered
        req = 3'b001; set_unit(0, 6'd12);
        @(negedge clk);
        check("flush T rdy", rdy, 3'b001);
        tick();
        flush = 1'b1;
        @(negedge clk);
        check("flush T+1 rdy", rdy, 0);
        check("flush T+1 cdb_wr", cdb_wr, 1);
        check("flush T+1 cdb_tag", cdb_tag, 12);
        tick();
        flush = 1'b0; req = 3'b000;
        @(negedge clk);
        check("flush T+2 cdb_wr", cdb_wr, 0);
        check("flush T+2 cdb_tag", cdb_tag, 0);
        check("flush T+2 cdb_wdata", cdb_wdata, 0);
`ifdef CDB_ARB_AGING_EN
        check("flush age0", 64'(dut.g_age[0].u_ctr.age), 0);
        check("flush age1", 64'(dut.g_age[1].u_ctr.age), 0);
        check("flush age2", 64'(dut.g_age[2].u_ctr.age), 0);
`endif
        tick();

        // Randomized traffic: hold a request until granted, mostly
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            g = rdy;
            tick();
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 24) == 0);
            for (int i = 0; i < N; i++) begin
                if (!(req[i] && !g[i]) || $urandom_range(0, 9) == 0) begin
                    req[i]            = ($urandom_range(0, 99) < 65);
                    tag[i*TW +: TW]   = TW'($urandom_range(0, 63));
                    wdata[i*DW +: DW] = $urandom;
                end
            end
            if ((c % 400) < 120) req[0] = 1'b1;
        end

        rst = 1'b0; flush = 1'b0; req = '0;
        tick();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cdb_arb.md
# cdb_arb

Parameterised common-data-bus arbiter for the out-of-order core. Collects writeback requests from N execution units (MDU, LSU, ALU, ...), grants at most one per cycle, and drives a registered CDB broadcast (wr/tag/wdata) to the ROB, reservation stations and register file. Priority is fixed by requester index, with an optional aging guard that bounds how long a low-priority unit can wait. A synchronous flush kills the in-flight broadcast and all aging state on branch mispredict.

## Interface
- N_REQ, 3, number of requesters; index 0 is highest fixed priority (0 = MDU, 1 = LSU, 2 = ALU in the core).
- TAG_W, 6, ROB tag width.
- DATA_W, 32, writeback data width.
- AGE_MAX, 7, wait-cycle threshold at which a requester is promoted; must be ≥1.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  pipeline kill; synchronous, active-high.
- req  in  N_REQ  per-unit writeback request.
- tag  in  N_REQ×TAG_W  per-unit ROB tag, valid when req[i].
- wdata  in  N_REQ×DATA_W  per-unit result, valid when req[i].
- rdy  out  N_REQ  grant; one-hot or zero, combinational.
- cdb_wr  out  1  broadcast valid.
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_wdata  out  DATA_W  broadcast data.

## Operation
- Handshake: a transfer on unit i occurs when req[i] && rdy[i]. The unit holds req/tag/wdata stable until that cycle, then may drop req or present its next result.
- rdy is computed from the current req and state only. It never depends on cdb_* outputs. At most one rdy bit is set per cycle. rdy[i]=0 whenever req[i]=0.
- Base selection: lowest index with req set wins.
- With aging (see Configuration), each requester has a wait counter age[i] of width $clog2(AGE_MAX+1):
  - req[i] && !rdy[i]: age[i] increments, saturating at AGE_MAX.
  - rdy[i], or !req[i], or flush: age[i] clears to 0.
  - If any age[i]==AGE_MAX, the lowest-index such requester wins, overriding base priority.
- Broadcast register: the cycle after a transfer, cdb_wr=1 and cdb_tag/cdb_wdata equal the granted tag/wdata. Without a transfer, all three are 0.
- Flush: in a flush cycle all rdy are 0 and no transfer occurs. The next cycle has cdb_wr=0, tag=0, wdata=0, and all ages are 0. A broadcast registered in the cycle before flush still appears in the flush cycle; consumers discard it.
- rst has priority over flush. rst clears cdb_wr, cdb_tag, cdb_wdata and all age counters to 0. rdy is 0 while rst is high.

## Timing
- Grant latency 0 (rdy in the request cycle). Broadcast latency 1 cycle after the transfer.
- Throughput: one broadcast per cycle, back-to-back, with no bubble between different winners.
- Worst-case wait with aging enabled:
  - A requester reaches AGE_MAX after AGE_MAX losing cycles.
  - If several requesters are aged at once, they are served lowest-index first.
  - Bound is therefore AGE_MAX + N_REQ − 1 cycles.
- Simultaneous events:
  - A request arriving in a cycle with all others idle is granted that cycle.
  - An aged requester dropping req loses its age.
  - A saturated counter stays at AGE_MAX until granted.

## Configuration
- CDB_ARB_AGING_EN defined: age counters and the promotion override are present, as described above.
- CDB_ARB_AGING_EN undefined: pure fixed priority with no counters; AGE_MAX is ignored. A continuously requesting index 0 starves all others indefinitely.

## Structure
- Package cdb_arb_pkg holds:
  - localparams CDB_TAG_W and CDB_DATA_W;
  - requester index constants (CDB_REQ_MDU=0, CDB_REQ_LSU=1, CDB_REQ_ALU=2);
  - typedef struct cdb_pkt_t {tag, wdata} shared with the consumers.
- One sub-module, cdb_arb_age_ctr, instantiated per requester under the macro: a saturating counter with clear, and an aged output flag.

## Test plan
- Reset: hold rst 3 cycles with req=3'b111 → rdy=0 and cdb_wr/tag/wdata=0 throughout; the first post-reset cycle grants rdy=3'b001.
- Priority: req=3'b110 with tag1=5, tag2=9 → rdy=3'b010; the next cycle cdb_wr=1, cdb_tag=5. Then drop req1 → rdy=3'b100; the following cycle cdb_tag=9.
- Back-to-back: unit 2 alone issues 4 consecutive transfers (tags 1..4) → cdb_wr high for 4 consecutive cycles with tags 1,2,3,4 and no bubble.
- Aging (macro on, AGE_MAX=7): req0 and req2 held continuously → unit 2 loses 7 cycles, is granted on the 8th, its age returns to 0, and unit 0 regains priority the next cycle.
- Aging off: same stimulus for 50 cycles → rdy[2] never asserts.
- Flush: transfer of tag 12 in cycle T, flush in cycle T+1 with req=3'b001 → cdb_tag=12 visible in T+1, rdy=0 in T+1, cdb_wr=0 in T+2, and all age counters at 0 in T+2.
